// File: rtl/globalDefinitions.sv
// Shared constants and the detection record used by the detection result queue.
// The detection entry is stored as {scale, y, x} with x in the least significant bits.
package globalDefinitions;

  localparam int supportedImageWidth  = 324;
  localparam int supportedImageHeight = 244;
  localparam int resultQueueDepth     = 256;
  localparam int scaleBits            = 8;

  localparam int detXBits = $clog2(supportedImageWidth);
  localparam int detYBits = $clog2(supportedImageHeight);

  localparam int dropCountBits = 16;

  typedef struct packed {
    logic [scaleBits-1:0] scale;
    logic [detYBits-1:0]  y;
    logic [detXBits-1:0]  x;
  } detection_t;

  // Occupancy needs one extra code so that a completely full queue is representable.
  function automatic int count_bits(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/result_queue_ram.sv
// Simple dual-port storage for the detection result queue: one write port and a
// registered read port with a synchronous reset on the output register.
module result_queue_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 25,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             re,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] rd_data_d;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read-before-write: a pop and a write to the same slot return the old entry.
  always_comb begin
    rd_data_d = rd_data_q;
    if (re) begin
      rd_data_d = mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/detection_result_queue.sv
// Circular queue of detector hits drained by the host, with a sticky overflow flag.
// Define RESULT_QUEUE_DROP_COUNT_EN to build the saturating drop counter; otherwise drop_count reads 0.
module detection_result_queue
  import globalDefinitions::*;
#(
  parameter int DEPTH  = resultQueueDepth,
  parameter int X_BITS = detXBits,
  parameter int Y_BITS = detYBits,
  parameter int S_BITS = scaleBits
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             det_valid,
  input  logic [X_BITS-1:0]                det_x,
  input  logic [Y_BITS-1:0]                det_y,
  input  logic [S_BITS-1:0]                det_scale,
  input  logic                             rd_req,
  output logic                             rd_valid,
  output logic [X_BITS+Y_BITS+S_BITS-1:0]  rd_data,
  output logic                             empty,
  output logic [count_bits(DEPTH)-1:0]     count,
  output logic                             overflow,
  input  logic                             clear_overflow,
  output logic [dropCountBits-1:0]         drop_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = count_bits(DEPTH);
  localparam int DW = X_BITS + Y_BITS + S_BITS;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rd_valid_q, rd_valid_d;
  logic          overflow_q, overflow_d;

  logic pop_acc;
  logic full;
  logic wr_acc;
  logic drop;
  logic ram_we;
  logic ram_re;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Handshake: a pop is accepted when rd_req=1 and the registered count is
  // non-zero; its data appears with rd_valid=1 exactly one cycle later. The
  // detector side has no backpressure, so a write to a full queue survives
  // only if a pop frees a slot in the same cycle.
  always_comb begin
    pop_acc    = rd_req && (count_q != '0);
    full       = (count_q == CW'(DEPTH));
    wr_acc     = det_valid && (!full || pop_acc);
    drop       = det_valid && full && !pop_acc;
    wr_ptr_d   = wr_acc  ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop_acc ? next_ptr(rd_ptr_q) : rd_ptr_q;
    count_d    = count_q + CW'(wr_acc) - CW'(pop_acc);
    rd_valid_d = pop_acc;
    overflow_d = overflow_q;
    if (clear_overflow) begin
      overflow_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign ram_we = wr_acc  && !reset;
  assign ram_re = pop_acc && !reset;

  result_queue_ram #(
    .DEPTH (DEPTH),
    .WIDTH (DW),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we      (ram_we),
    .wr_addr (wr_ptr_q),
    .wr_data ({det_scale, det_y, det_x}),
    .re      (ram_re),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

`ifdef RESULT_QUEUE_DROP_COUNT_EN
  logic [dropCountBits-1:0] drop_count_q, drop_count_d;

  // A clear and a drop in the same cycle leave exactly one counted drop.
  always_comb begin
    drop_count_d = drop_count_q;
    if (clear_overflow) begin
      drop_count_d = '0;
    end
    if (drop && (drop_count_d != {dropCountBits{1'b1}})) begin
      drop_count_d = drop_count_d + dropCountBits'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count_q <= '0;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

  assign drop_count = drop_count_q;
`else
  assign drop_count = '0;
`endif

  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_detection_result_queue.sv
// Directed bench for detection_result_queue: pops push expected entries into a
// scoreboard queue that a negedge monitor drains whenever rd_valid is seen.
module tb_detection_result_queue;
  import globalDefinitions::*;

  localparam int DEPTH = 256;
  localparam int XB    = 9;
  localparam int YB    = 8;
  localparam int SB    = 8;
  localparam int DW    = XB + YB + SB;
  localparam int CW    = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          det_valid;
  logic [XB-1:0] det_x;
  logic [YB-1:0] det_y;
  logic [SB-1:0] det_scale;
  logic          rd_req;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          clear_overflow;
  logic [15:0]   drop_count;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model_q[$];
  int            checks = 0;
  int            errors = 0;
  logic          exp_ovf = 1'b0;
  int            exp_dc = 0;
  logic [DW-1:0] last_rd = '0;

  detection_result_queue #(
    .DEPTH (DEPTH), .X_BITS (XB), .Y_BITS (YB), .S_BITS (SB)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .det_valid      (det_valid),
    .det_x          (det_x),
    .det_y          (det_y),
    .det_scale      (det_scale),
    .rd_req         (rd_req),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .empty          (empty),
    .count          (count),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .drop_count     (drop_count)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pack(input logic [XB-1:0] x, input logic [YB-1:0] y,
                                         input logic [SB-1:0] s);
    detection_t d;
    d.x     = x;
    d.y     = y;
    d.scale = s;
    return d;
  endfunction

  function automatic int exp_drop_count();
`ifdef RESULT_QUEUE_DROP_COUNT_EN
    return exp_dc;
`else
    return 0;
`endif
  endfunction

  // driver: one clock cycle of stimulus, model update, and registered-output checks
  task automatic step(input logic rst, input logic dv, input logic [XB-1:0] x,
                      input logic [YB-1:0] y, input logic [SB-1:0] s,
                      input logic rr, input logic clr);
    logic          pop_ok;
    logic          drop;
    logic [DW-1:0] popped;
    pop_ok = !rst && rr && (model_q.size() > 0);
    drop   = !rst && dv && (model_q.size() == DEPTH) && !pop_ok;
    popped = last_rd;
    reset = rst; det_valid = dv; det_x = x; det_y = y; det_scale = s;
    rd_req = rr; clear_overflow = clr;
    if (pop_ok) begin
      popped = model_q.pop_front();
      exp_q.push_back(popped);
    end
    if (!rst && dv && !drop) model_q.push_back(pack(x, y, s));
    if (rst) begin
      exp_ovf = 1'b0;
      exp_dc  = 0;
    end else begin
      if (clr) begin
        exp_ovf = 1'b0;
        exp_dc  = 0;
      end
      if (drop) begin
        exp_ovf = 1'b1;
        if (exp_dc < 65535) exp_dc++;
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      model_q.delete();
      exp_q.delete();
      popped = '0;
    end
    chk("rd_valid", {31'd0, rd_valid}, {31'd0, pop_ok});
    if (!pop_ok) chk("rd_data_hold", {7'd0, rd_data}, {7'd0, popped});
    last_rd = popped;
    chk("count", {23'd0, count}, model_q.size());
    chk("empty", {31'd0, empty}, {31'd0, model_q.size() == 0});
    chk("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
    chk("drop_count", {16'd0, drop_count}, exp_drop_count());
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [XB-1:0] x, input logic [YB-1:0] y, input logic [SB-1:0] s);
    step(1'b0, 1'b1, x, y, s, 1'b0, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
  endtask

  // monitor: every presented entry must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got %0h expected no rd_valid at %0t", rd_data, $time);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          errors++;
          $display("FAIL rd_data: got %0h expected %0h at %0t", rd_data, e, $time);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; det_valid = 1'b0; det_x = '0; det_y = '0; det_scale = '0;
    rd_req = 1'b0; clear_overflow = 1'b0;
    @(posedge clk); #1;
    step(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 9'd3, 8'd3, 8'd3, 1'b1, 1'b0);
    chk("reset_rd_data", {7'd0, rd_data}, 32'd0);

    // three hand-packed detections drained on consecutive cycles
    wr(9'd1, 8'd2, 8'd0);
    wr(9'd324, 8'd244, 8'd7);
    wr(9'd0, 8'd0, 8'd255);
    chk("count_3", {23'd0, count}, 32'd3);
    pop(); chk("rd_data_a", {7'd0, rd_data}, 32'h0000401);
    pop(); chk("rd_data_b", {7'd0, rd_data}, 32'h00FE944);
    pop(); chk("rd_data_c", {7'd0, rd_data}, 32'h1FE0000);
    chk("empty_after_3", {31'd0, empty}, 32'd1);
    idle(2);

    // fill, overflow by two, clear, then clear and drop together
    for (int i = 0; i < DEPTH; i++) wr(XB'(i), YB'(i) ^ 8'hA5, SB'(i));
    wr(9'h1AA, 8'h11, 8'h22);
    wr(9'h0BB, 8'h33, 8'h44);
    chk("count_full", {23'd0, count}, 32'd256);
    chk("overflow_set", {31'd0, overflow}, 32'd1);
`ifdef RESULT_QUEUE_DROP_COUNT_EN
    chk("drop_count_2", {16'd0, drop_count}, 32'd2);
`else
    chk("drop_count_off", {16'd0, drop_count}, 32'd0);
`endif
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
    chk("overflow_clr", {31'd0, overflow}, 32'd0);
    step(1'b0, 1'b1, 9'd7, 8'd7, 8'd7, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);

    // full queue, write and pop together: write kept, oldest entry returned
    step(1'b0, 1'b1, 9'h155, 8'h66, 8'h77, 1'b1, 1'b0);
    chk("rd_data_oldest", {7'd0, rd_data}, {7'd0, pack(9'd0, 8'hA5, 8'd0)});
    chk("count_still_full", {23'd0, count}, 32'd256);
    for (int i = 0; i < DEPTH; i++) pop();
    idle(2);

    // empty queue, write and pop together: pop ignored
    step(1'b0, 1'b1, 9'd5, 8'd6, 8'd7, 1'b1, 1'b0);
    pop();
    chk("rd_data_empty_wr", {7'd0, rd_data}, {7'd0, pack(9'd5, 8'd6, 8'd7)});
    pop();
    idle(2);

    // pointer wrap
    for (int i = 0; i < 200; i++) wr(XB'(i * 3), YB'(i + 17), SB'(255 - i));
    for (int i = 0; i < 200; i++) pop();
    for (int i = 0; i < 100; i++) wr(XB'(i * 5 + 1), YB'(i ^ 8'h3C), SB'(i));
    for (int i = 0; i < 100; i++) pop();
    idle(2);

    // reset with entries stored and a pop in flight
    for (int i = 0; i < 10; i++) wr(XB'(i + 100), YB'(i), SB'(i));
    step(1'b1, 1'b1, 9'd9, 8'd9, 8'd9, 1'b1, 1'b0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_count", {23'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    wr(9'd42, 8'd43, 8'd44);
    wr(9'd45, 8'd46, 8'd47);
    pop();
    chk("post_rst_data", {7'd0, rd_data}, {7'd0, pack(9'd42, 8'd43, 8'd44)});
    pop();
    pop();
    idle(3);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
